// File: rtl/audio_seq_mixer.sv
// -----------------------------------------------------------------------------
// audio_seq_mixer
//   N-channel square-wave step sequencer feeding a 1-bit sigma-delta mixer.
//   Each channel owns a row of a small pattern RAM holding half-periods (in
//   synth ticks, 0 = rest). While playing, every step latches one half-period
//   per channel, and the oscillators sound for the gated part of the step. The
//   number of channels whose square is high is accumulated against full scale
//   to produce a PDM bitstream.
//
//   Optional feature macro: AUDIO_VOLUME_EN
//     defined   : vol port present, channel weight 0..3, full scale 3*CHANNELS
//     undefined : each sounding channel weighs 1, full scale CHANNELS
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high (also clears pattern RAM)
//   run         in   1 = play, 0 = stop/idle
//   wr_en       in   pattern write strobe (accepted in any state)
//   wr_ch       in   target channel; values >= CHANNELS are ignored
//   wr_addr     in   target step
//   wr_data     in   half-period to store
//   vol         in   2 bits per channel (AUDIO_VOLUME_EN only)
//   step        out  current step index
//   step_strobe out  1-cycle pulse at each step start
//   busy        out  1 while playing
//   audio       out  PDM audio bitstream
// -----------------------------------------------------------------------------
module audio_seq_mixer #(
   parameter int CHANNELS  = 2,
   parameter int STEPS     = 16,
   parameter int HP_W      = 7,
   parameter int SYNTH_DIV = 1024,
   parameter int SEQ_DIV   = 64,
   parameter int STEP_LEN  = 20,
   parameter int GATE_LEN  = 10
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              run,
   input  logic                                              wr_en,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
   input  logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0]       wr_addr,
   input  logic [HP_W-1:0]                                   wr_data,
`ifdef AUDIO_VOLUME_EN
   input  logic [2*CHANNELS-1:0]                             vol,
`endif
   output logic [((STEPS > 1) ? $clog2(STEPS) : 1)-1:0]       step,
   output logic                                              step_strobe,
   output logic                                              busy,
   output logic                                              audio
);

   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int PRE_W  = (SYNTH_DIV > 1) ? $clog2(SYNTH_DIV) : 1;
   localparam int SDV_W  = (SEQ_DIV > 1) ? $clog2(SEQ_DIV) : 1;
   localparam int SEQ_W  = $clog2(STEP_LEN + 1);
`ifdef AUDIO_VOLUME_EN
   localparam int FS     = 3 * CHANNELS;
`else
   localparam int FS     = CHANNELS;
`endif
   localparam int ACC_W  = $clog2(2 * FS);
   localparam int SUM_W  = ACC_W + 1;
   localparam int MIX_W  = $clog2(FS + 1);

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SYNTH_DIV - 1);
   localparam logic [SDV_W-1:0]  SDV_LAST  = SDV_W'(SEQ_DIV - 1);
   localparam logic [SEQ_W-1:0]  STEP_LAST = SEQ_W'(STEP_LEN - 1);
   localparam logic [SEQ_W-1:0]  GATE_V    = SEQ_W'(GATE_LEN);
   localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(STEPS - 1);
   localparam logic [CH_W:0]     CH_LIM    = (CH_W + 1)'(CHANNELS);
   localparam logic [SUM_W-1:0]  FS_V      = SUM_W'(FS);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t              state;
   logic [PRE_W-1:0]    pre;         // clk cycles within the current synth tick
   logic [SDV_W-1:0]    sdiv;        // synth ticks within the current seq tick
   logic [SEQ_W-1:0]    sticks;      // seq ticks elapsed within the current step
   logic [HP_W-1:0]     hp   [CHANNELS];
   logic [HP_W-1:0]     cnt  [CHANNELS];
   logic [CHANNELS-1:0] sq;
   logic [ACC_W-1:0]    acc;
   logic [HP_W-1:0]     ram  [CHANNELS][STEPS];

   logic                synth_tick;
   logic                seq_tick;
   logic                step_end;
   logic                gate;
   logic [STEP_W-1:0]   step_next;
   logic [MIX_W-1:0]    mix;
   logic [SUM_W-1:0]    sum;

   always_comb begin
      synth_tick = (state == PLAY) && (pre == PRE_LAST);
      seq_tick   = synth_tick && (sdiv == SDV_LAST);
      step_end   = seq_tick && (sticks == STEP_LAST);
      gate       = (sticks < GATE_V);
      step_next  = (step == STEP_MAX) ? '0 : step + STEP_W'(1);
      // Squares are masked by the gate directly so a channel goes silent on
      // the very first cycle past the gate, not one cycle later.
      mix = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (sq[c] && gate) begin
`ifdef AUDIO_VOLUME_EN
            mix = mix + MIX_W'(vol[2*c +: 2]);
`else
            mix = mix + MIX_W'(1);
`endif
         end
      end
      sum = SUM_W'(acc) + SUM_W'(mix);
   end

   // Pattern RAM: cleared by reset, written whenever wr_en is high. The hp
   // latch below reads the old contents on a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int s = 0; s < STEPS; s++)
               ram[c][s] <= '0;
      end else if (wr_en && ({1'b0, wr_ch} < CH_LIM)) begin
         ram[wr_ch][wr_addr] <= wr_data;
      end
   end

   // Sequencer FSM, oscillators and sigma-delta mixer
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         step        <= '0;
         step_strobe <= 1'b0;
         busy        <= 1'b0;
         audio       <= 1'b0;
         pre         <= '0;
         sdiv        <= '0;
         sticks      <= '0;
         acc         <= '0;
         sq          <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            hp[c]  <= '0;
            cnt[c] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               busy        <= 1'b0;
               audio       <= 1'b0;
               step_strobe <= 1'b0;
               pre         <= '0;
               sdiv        <= '0;
               sticks      <= '0;
               acc         <= '0;
               sq          <= '0;
               for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
               if (run) begin
                  state       <= PLAY;
                  busy        <= 1'b1;
                  step        <= '0;
                  step_strobe <= 1'b1;
                  for (int c = 0; c < CHANNELS; c++) hp[c] <= ram[c][0];
               end
            end

            PLAY: begin
               if (!run) begin
                  // Step index is kept; everything else returns to rest.
                  state       <= IDLE;
                  busy        <= 1'b0;
                  audio       <= 1'b0;
                  step_strobe <= 1'b0;
                  pre         <= '0;
                  sdiv        <= '0;
                  sticks      <= '0;
                  acc         <= '0;
                  sq          <= '0;
                  for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
               end else begin
                  step_strobe <= step_end;
                  pre <= synth_tick ? '0 : pre + PRE_W'(1);
                  if (synth_tick) sdiv <= seq_tick ? '0 : sdiv + SDV_W'(1);
                  if (seq_tick) sticks <= step_end ? '0 : sticks + SEQ_W'(1);

                  if (step_end) begin
                     step <= step_next;
                     sq   <= '0;
                     for (int c = 0; c < CHANNELS; c++) begin
                        hp[c]  <= ram[c][step_next];
                        cnt[c] <= '0;
                     end
                  end else begin
                     for (int c = 0; c < CHANNELS; c++) begin
                        if (!gate) begin
                           sq[c] <= 1'b0;
                        end else if (synth_tick && (hp[c] != '0)) begin
                           if (cnt[c] == hp[c] - HP_W'(1)) begin
                              sq[c]  <= ~sq[c];
                              cnt[c] <= '0;
                           end else begin
                              cnt[c] <= cnt[c] + HP_W'(1);
                           end
                        end
                     end
                  end

                  // First-order sigma-delta: overflow past full scale emits a 1.
                  if (sum >= FS_V) begin
                     acc   <= ACC_W'(sum - FS_V);
                     audio <= 1'b1;
                  end else begin
                     acc   <= ACC_W'(sum);
                     audio <= 1'b0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_seq_mixer.sv
module tb_audio_seq_mixer;

   localparam int CHANNELS   = 2;
   localparam int STEPS      = 4;
   localparam int HP_W       = 4;
   localparam int SYNTH_DIV  = 4;
   localparam int SEQ_DIV    = 2;
   localparam int STEP_LEN   = 4;
   localparam int GATE_LEN   = 2;
   localparam int STEP_CYC   = SYNTH_DIV * SEQ_DIV * STEP_LEN;
   localparam int GATE_TICKS = GATE_LEN * SEQ_DIV;
`ifdef AUDIO_VOLUME_EN
   localparam int FS = 3 * CHANNELS;
`else
   localparam int FS = CHANNELS;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       wr_en = 1'b0;
   logic [0:0] wr_ch = '0;
   logic [1:0] wr_addr = '0;
   logic [3:0] wr_data = '0;
`ifdef AUDIO_VOLUME_EN
   logic [3:0] vol = '0;
`endif
   logic [1:0] step;
   logic       step_strobe;
   logic       busy;
   logic       audio;

   always #5 clk = ~clk;

   audio_seq_mixer #(
      .CHANNELS(CHANNELS), .STEPS(STEPS), .HP_W(HP_W), .SYNTH_DIV(SYNTH_DIV),
      .SEQ_DIV(SEQ_DIV), .STEP_LEN(STEP_LEN), .GATE_LEN(GATE_LEN)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef AUDIO_VOLUME_EN
      .vol(vol),
`endif
      .step(step), .step_strobe(step_strobe), .busy(busy), .audio(audio)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state: pattern memory, play flag, position in step.
   int m_ram [CHANNELS][STEPS];
   int m_hp  [CHANNELS];
   bit m_play = 0;
   int m_k = 0;
   int m_step = 0;
   int m_acc = 0;
   bit m_strobe = 0;
   bit m_busy = 0;
   bit m_audio = 0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Square level of a channel with half-period hp, k cycles into a step.
   function automatic int sq_model(input int hp, input int k);
      int t;
      t = k / SYNTH_DIV;
      if (hp == 0 || t >= GATE_TICKS) return 0;
      return (t / hp) % 2;
   endfunction

   task automatic model_edge();
      int mix;
      mix = 0;
      if (rst) begin
         foreach (m_ram[c, s]) m_ram[c][s] = 0;
         foreach (m_hp[c]) m_hp[c] = 0;
         m_play = 0; m_k = 0; m_step = 0; m_acc = 0;
         m_strobe = 0; m_busy = 0; m_audio = 0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (m_play && sq_model(m_hp[c], m_k) == 1) begin
`ifdef AUDIO_VOLUME_EN
               mix += (vol >> (2*c)) & 3;
`else
               mix += 1;
`endif
            end
         end
         if (!m_play) begin
            m_audio = 0; m_acc = 0; m_busy = 0; m_strobe = 0;
            if (run) begin
               m_play = 1; m_busy = 1; m_strobe = 1; m_step = 0; m_k = 0;
               for (int c = 0; c < CHANNELS; c++) m_hp[c] = m_ram[c][0];
            end
         end else if (!run) begin
            m_play = 0; m_busy = 0; m_audio = 0; m_acc = 0; m_strobe = 0; m_k = 0;
         end else begin
            if (m_acc + mix >= FS) begin
               m_acc = m_acc + mix - FS; m_audio = 1;
            end else begin
               m_acc = m_acc + mix; m_audio = 0;
            end
            if (m_k == STEP_CYC - 1) begin
               m_k = 0;
               m_step = (m_step + 1) % STEPS;
               m_strobe = 1;
               for (int c = 0; c < CHANNELS; c++) m_hp[c] = m_ram[c][m_step];
            end else begin
               m_k++;
               m_strobe = 0;
            end
         end
         if (wr_en && int'(wr_ch) < CHANNELS) m_ram[wr_ch][wr_addr] = int'(wr_data);
      end
   endtask

   task automatic tick(input bit r, input bit rn, input bit we, input int ch,
                       input int ad, input int d);
      rst = r; run = rn; wr_en = we;
      wr_ch = 1'(ch); wr_addr = 2'(ad); wr_data = 4'(d);
`ifdef AUDIO_VOLUME_EN
      vol = 4'($urandom_range(0, 15));
`endif
      @(posedge clk);
      model_edge();
      #1;
      chk_val("step",   32'(step),        32'(m_step));
      chk_val("strobe", 32'(step_strobe), 32'(m_strobe));
      chk_val("busy",   32'(busy),        32'(m_busy));
      chk_val("audio",  32'(audio),       32'(m_audio));
   endtask

   task automatic run_for(input int n);
      for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, 0);
   endtask

   function automatic int rand_hp();
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) return 0;
      if (sel < 8) return $urandom_range(1, 3);
      return $urandom_range(0, 15);
   endfunction

   initial begin
      bit run_cur;
      bit wrote;
      // Reset state
      tick(1, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);

      // All rests: silent playback, strobe every step
      run_for(5 * STEP_CYC);
      tick(0, 0, 0, 0, 0, 0);

      // Single channel, hp=1 on step 0
      tick(0, 0, 1, 0, 0, 1);
      run_for(2 * STEPS * STEP_CYC);

      // Reset mid-play clears pattern memory: playback goes silent
      tick(1, 1, 0, 0, 0, 0);
      run_for(2 * STEP_CYC);
      tick(0, 0, 0, 0, 0, 0);

      // Both channels hp=2 on step 0
      tick(0, 0, 1, 0, 0, 2);
      tick(0, 0, 1, 1, 0, 2);
      run_for(STEP_CYC + 3);

      // Write ch1 step2 while step 2 is playing; it sounds on the next visit
      wrote = 0;
      for (int i = 0; i < 4 * STEP_CYC && !wrote; i++) begin
         if (m_step == 2 && m_k == 5) begin
            tick(0, 1, 1, 1, 2, 3);
            wrote = 1;
         end else begin
            tick(0, 1, 0, 0, 0, 0);
         end
      end
      chk_val("wr_step2_hit", 32'(wrote), 32'd1);
      run_for(STEPS * STEP_CYC + 8);

      // Stop mid-step, then restart at step 0
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      run_for(STEP_CYC + 10);

      // Randomized traffic: writes (including on latch cycles), stops, resets
      run_cur = 1;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 149) == 0) run_cur = ~run_cur;
         tick(($urandom_range(0, 1499) == 0), run_cur,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
              $urandom_range(0, STEPS - 1), rand_hp());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
